keyboard_movement_decoder: RTL and testbench
============================================

Name: keyboard_movement_decoder

Overview:
- Upstream of the player update stage. Consumes PS/2 Set-2 scan-code bytes from the keyboard receiver.
- Tracks which movement keys are held: arrows, plus optional WASD.
- Drives the four movement levels (turn_right, turn_left, move_forward, move_backward) as a one-hot-or-zero vector, because the update stage acts only on exactly one asserted bit.
- Resolves multiple held keys by most-recently-pressed, with a fixed-priority fallback.

Parameters:
- ENABLE_WASD, 1: when 1, non-extended W/S/A/D alias up/down/left/right.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- scan_code  in  8  received PS/2 byte
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle
- clear  in  1  synchronous; drops all held keys (focus loss / menu)
- turn_right  out  1  resolved RIGHT
- turn_left  out  1  resolved LEFT
- move_forward  out  1  resolved UP
- move_backward  out  1  resolved DOWN
- held  out  4  raw held set {right, left, up, down}
- seq_error  out  1  one-cycle pulse on a malformed prefix sequence

Behaviour:
- Reset (resetn=0, async):
  - parser state=IDLE; held=0; last=NONE; all outputs 0; seq_error=0.
- Parser FSM, advances only on scan_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(code, ext=0) -> IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (redundant prefix, no error); other -> make(code, ext=1) -> IDLE.
  - BRK: F0 -> BRK; E0 -> EXT with seq_error pulse (malformed); other -> break(code, ext=0) -> IDLE.
  - EXT_BRK: E0 or F0 -> IDLE with seq_error pulse; other -> break(code, ext=1) -> IDLE.
- Key map:
  - ext=1: 75=UP, 72=DOWN, 6B=LEFT, 74=RIGHT.
  - ext=0 with ENABLE_WASD=1: 1D=UP, 1B=DOWN, 1C=LEFT, 23=RIGHT.
  - All other codes (including E1 pause bytes) are ignored and leave the FSM in IDLE.
- Make of a mapped key: set its held bit; last <= that key. Typematic repeats are idempotent.
- Break of a mapped key: clear its held bit. If it equals last, last <= NONE.
- Arrow and WASD aliases share one held bit. A break from either source clears the bit.
- Resolution, combinational from registers:
  - if last != NONE and held[last]: assert only last.
  - else: fixed priority UP > DOWN > LEFT > RIGHT among held bits.
  - held=0: all four movement outputs 0.
  - The four movement outputs are never more than one-hot.
- Latency: held and the movement outputs reflect a byte one cycle after the scan_valid that completes its sequence.
- clear:
  - Takes priority over a same-cycle scan_valid: held=0, last=NONE, FSM=IDLE, and the byte is dropped.
  - clear asserted mid-sequence (e.g. after E0) aborts the sequence with no seq_error.
- scan_valid held for consecutive cycles: each cycle is a distinct byte.
- Async reset mid-sequence: immediate return to reset values. No partial key event is applied.

Decomposition:
- Shared package (game_pkg):
  - scan-code constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, arrow and WASD codes.
  - direction index constants: DIR_DOWN=0, DIR_UP=1, DIR_LEFT=2, DIR_RIGHT=3.
  - DIR_NONE encoding for the 3-bit last register.
- Natural sub-module: scan_code_parser. Contains the FSM and key map. Emits a one-cycle key_event with {is_make, dir_valid, dir}.
- The top level holds held/last and the resolver.

Test Plan:
- Reset then E0,75 -> move_forward=1 one cycle after 75; held=4'b0010. Then E0,F0,75 -> all outputs 0; held=0.
- E0,75 then E0,6B (UP then LEFT held) -> turn_left=1, move_forward=0. Then E0,F0,6B -> move_forward=1 (fallback to priority).
- Hold DOWN and RIGHT (E0,72 then E0,74), release RIGHT -> move_backward=1. Release DOWN -> all 0. Then hold all four keys -> exactly one output high, at every cycle.
- 1D (W, ENABLE_WASD=1) -> move_forward=1. Then E0,F0,75 -> released. Rerun with ENABLE_WASD=0: 1D -> no change.
- Malformed F0,E0,74 -> seq_error pulses on the E0 cycle; 74 is then processed as an extended make, so turn_right=1.
- E0 followed by clear in the same cycle as 75 -> held stays 0 and FSM=IDLE. Assert resetn=0 asynchronously while held=4'b1000 -> outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants and the key-event type for the keyboard front end.
package game_pkg;

   // PS/2 Set-2 prefix bytes
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Extended (E0-prefixed) arrow codes
   localparam logic [7:0] PS2_ARROW_UP    = 8'h75;
   localparam logic [7:0] PS2_ARROW_DOWN  = 8'h72;
   localparam logic [7:0] PS2_ARROW_LEFT  = 8'h6B;
   localparam logic [7:0] PS2_ARROW_RIGHT = 8'h74;

   // Non-extended WASD codes
   localparam logic [7:0] PS2_KEY_W = 8'h1D;
   localparam logic [7:0] PS2_KEY_S = 8'h1B;
   localparam logic [7:0] PS2_KEY_A = 8'h1C;
   localparam logic [7:0] PS2_KEY_D = 8'h23;

   // Direction indices; they double as bit positions in held
   localparam logic [1:0] DIR_DOWN  = 2'd0;
   localparam logic [1:0] DIR_UP    = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   // 3-bit last-pressed encoding: MSB set means no key
   localparam logic [2:0] DIR_NONE = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } parser_state_t;

   typedef struct packed {
      logic       is_make;
      logic       dir_valid;
      logic [1:0] dir;
   } key_event_t;

   // Map a completed code to a direction; unmapped codes give dir_valid=0.
   function automatic key_event_t decode_key(input logic [7:0] code,
                                             input logic       ext,
                                             input logic       wasd_en,
                                             input logic       is_make);
      key_event_t ev;
      ev.is_make   = is_make;
      ev.dir_valid = 1'b0;
      ev.dir       = DIR_DOWN;
      if (ext) begin
         case (code)
            PS2_ARROW_UP:    begin ev.dir_valid = 1'b1; ev.dir = DIR_UP;    end
            PS2_ARROW_DOWN:  begin ev.dir_valid = 1'b1; ev.dir = DIR_DOWN;  end
            PS2_ARROW_LEFT:  begin ev.dir_valid = 1'b1; ev.dir = DIR_LEFT;  end
            PS2_ARROW_RIGHT: begin ev.dir_valid = 1'b1; ev.dir = DIR_RIGHT; end
            default: ;
         endcase
      end else if (wasd_en) begin
         case (code)
            PS2_KEY_W: begin ev.dir_valid = 1'b1; ev.dir = DIR_UP;    end
            PS2_KEY_S: begin ev.dir_valid = 1'b1; ev.dir = DIR_DOWN;  end
            PS2_KEY_A: begin ev.dir_valid = 1'b1; ev.dir = DIR_LEFT;  end
            PS2_KEY_D: begin ev.dir_valid = 1'b1; ev.dir = DIR_RIGHT; end
            default: ;
         endcase
      end
      return ev;
   endfunction

endpackage

// File: rtl/scan_code_parser.sv
// Prefix-tracking parser: turns the E0/F0 byte stream into make/break key events.
module scan_code_parser
   import game_pkg::*;
#(
   parameter bit ENABLE_WASD = 1'b1
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       clear,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output key_event_t key_event,
   output logic       seq_error
);

   parser_state_t state, state_nxt;

   // Prefix state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next state plus same-cycle key event / error pulse; clear aborts any sequence silently
   always_comb begin
      state_nxt = state;
      key_event = '0;
      seq_error = 1'b0;
      if (clear) begin
         state_nxt = ST_IDLE;
      end else if (scan_valid) begin
         case (state)
            ST_IDLE: begin
               if (scan_code == PS2_EXT)      state_nxt = ST_EXT;
               else if (scan_code == PS2_BRK) state_nxt = ST_BRK;
               else key_event = decode_key(scan_code, 1'b0, ENABLE_WASD, 1'b1);
            end
            ST_EXT: begin
               if (scan_code == PS2_BRK)      state_nxt = ST_EXT_BRK;
               else if (scan_code == PS2_EXT) state_nxt = ST_EXT;
               else begin
                  key_event = decode_key(scan_code, 1'b1, ENABLE_WASD, 1'b1);
                  state_nxt = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (scan_code == PS2_BRK) state_nxt = ST_BRK;
               else if (scan_code == PS2_EXT) begin
                  // F0 E0 is out of order; recover by treating E0 as a fresh prefix
                  state_nxt = ST_EXT;
                  seq_error = 1'b1;
               end else begin
                  key_event = decode_key(scan_code, 1'b0, ENABLE_WASD, 1'b0);
                  state_nxt = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               if (scan_code == PS2_EXT || scan_code == PS2_BRK) begin
                  state_nxt = ST_IDLE;
                  seq_error = 1'b1;
               end else begin
                  key_event = decode_key(scan_code, 1'b1, ENABLE_WASD, 1'b0);
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/keyboard_movement_decoder.sv
// Tracks held movement keys and resolves them to a one-hot-or-zero movement vector.
module keyboard_movement_decoder
   import game_pkg::*;
#(
   parameter bit ENABLE_WASD = 1'b1
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic       clear,
   output logic       turn_right,
   output logic       turn_left,
   output logic       move_forward,
   output logic       move_backward,
   output logic [3:0] held,
   output logic       seq_error
);

   key_event_t key_event;
   logic [2:0] last;
   logic [3:0] resolved;

   scan_code_parser #(.ENABLE_WASD(ENABLE_WASD)) u_parser (
      .clock      (clock),
      .resetn     (resetn),
      .clear      (clear),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .key_event  (key_event),
      .seq_error  (seq_error)
   );

   // Held set and most-recent key; arrow and WASD share a bit so either break releases it
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         held <= '0;
         last <= DIR_NONE;
      end else if (clear) begin
         held <= '0;
         last <= DIR_NONE;
      end else if (key_event.dir_valid) begin
         if (key_event.is_make) begin
            held[key_event.dir] <= 1'b1;
            last                <= {1'b0, key_event.dir};
         end else begin
            held[key_event.dir] <= 1'b0;
            if (last == {1'b0, key_event.dir}) last <= DIR_NONE;
         end
      end
   end

   // Most-recent key wins while still held, else fixed priority UP > DOWN > LEFT > RIGHT
   always_comb begin
      resolved = '0;
      if (last != DIR_NONE && held[last[1:0]]) resolved[last[1:0]] = 1'b1;
      else if (held[DIR_UP])                   resolved[DIR_UP]    = 1'b1;
      else if (held[DIR_DOWN])                 resolved[DIR_DOWN]  = 1'b1;
      else if (held[DIR_LEFT])                 resolved[DIR_LEFT]  = 1'b1;
      else if (held[DIR_RIGHT])                resolved[DIR_RIGHT] = 1'b1;
   end

   assign turn_right    = resolved[DIR_RIGHT];
   assign turn_left     = resolved[DIR_LEFT];
   assign move_forward  = resolved[DIR_UP];
   assign move_backward = resolved[DIR_DOWN];

endmodule

// File: tb/tb_keyboard_movement_decoder.sv
// Scoreboard bench: two instances (WASD on/off) share one byte stream.
module tb_keyboard_movement_decoder;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] scan_code = '0;
   logic       scan_valid = 1'b0;
   logic       clear = 1'b0;

   logic       tr_w, tl_w, mf_w, mb_w, err_w;
   logic [3:0] held_w;
   logic       tr_n, tl_n, mf_n, mb_n, err_n;
   logic [3:0] held_n;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   typedef struct {
      string      tag;
      logic [3:0] held_w, mv_w, held_n, mv_n;
   } exp_t;
   exp_t exp_q[$];

   // current expectation, {right,left,up,down} order for both held and movement
   logic [3:0] xh_w = '0, xm_w = '0, xh_n = '0, xm_n = '0;
   string      cur_tag = "reset";

   always #5 clock = ~clock;

   keyboard_movement_decoder #(.ENABLE_WASD(1'b1)) dut (
      .clock(clock), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
      .clear(clear), .turn_right(tr_w), .turn_left(tl_w), .move_forward(mf_w),
      .move_backward(mb_w), .held(held_w), .seq_error(err_w));

   keyboard_movement_decoder #(.ENABLE_WASD(1'b0)) dut_nw (
      .clock(clock), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
      .clear(clear), .turn_right(tr_n), .turn_left(tl_n), .move_forward(mf_n),
      .move_backward(mb_n), .held(held_n), .seq_error(err_n));

   wire [3:0] mv_w = {tr_w, tl_w, mf_w, mb_w};
   wire [3:0] mv_n = {tr_n, tl_n, mf_n, mb_n};

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", tag, got, want);
      end
   endtask

   // Pop one expectation per byte on the falling edge after it was registered
   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.tag, " held"},    {4'b0, held_w}, {4'b0, e.held_w});
         chk({e.tag, " mv"},      {4'b0, mv_w},   {4'b0, e.mv_w});
         chk({e.tag, " held_nw"}, {4'b0, held_n}, {4'b0, e.held_n});
         chk({e.tag, " mv_nw"},   {4'b0, mv_n},   {4'b0, e.mv_n});
      end
      if (resetn) begin
         chk("onehot", {7'b0, $countones(mv_w) <= 1}, 8'd1);
         chk("onehot_nw", {7'b0, $countones(mv_n) <= 1}, 8'd1);
      end
   end

   task automatic set_exp(input logic [3:0] h, input logic [3:0] m);
      xh_w = h; xm_w = m; xh_n = h; xm_n = m;
   endtask

   // Drive one cycle starting just after a rising edge; seq_error is checked mid-cycle
   task automatic send(input logic [7:0] code, input logic vld, input logic clr, input logic err);
      exp_t e;
      scan_code = code; scan_valid = vld; clear = clr;
      @(negedge clock);
      chk({cur_tag, " seq_error"},    {7'b0, err_w}, {7'b0, err});
      chk({cur_tag, " seq_error_nw"}, {7'b0, err_n}, {7'b0, err});
      @(posedge clock);
      #1;
      scan_valid = 1'b0; clear = 1'b0;
      e.tag = cur_tag; e.held_w = xh_w; e.mv_w = xm_w; e.held_n = xh_n; e.mv_n = xm_n;
      exp_q.push_back(e);
   endtask

   task automatic byte_in(input logic [7:0] code);
      send(code, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic async_check(input string tag);
      chk({tag, " held"}, {4'b0, held_w}, 8'h00);
      chk({tag, " mv"},   {4'b0, mv_w},   8'h00);
      chk({tag, " err"},  {7'b0, err_w},  8'h00);
      chk({tag, " held_nw"}, {4'b0, held_n}, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clock);
      @(negedge clock);
      async_check("reset");
      resetn = 1'b1;
      @(posedge clock); #1;

      // Single arrow press and release
      cur_tag = "up_make";     byte_in(8'hE0); set_exp(4'b0010, 4'b0010); byte_in(8'h75);
      cur_tag = "up_break";    byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0000, 4'b0000); byte_in(8'h75);

      // Most recent wins, then priority fallback; typematic repeat is idempotent
      cur_tag = "up_again";    byte_in(8'hE0); set_exp(4'b0010, 4'b0010); byte_in(8'h75);
      cur_tag = "up_repeat";   byte_in(8'hE0); byte_in(8'h75);
      cur_tag = "left_make";   byte_in(8'hE0); set_exp(4'b0110, 4'b0100); byte_in(8'h6B);
      cur_tag = "left_break";  byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0010, 4'b0010); byte_in(8'h6B);
      cur_tag = "up_rel";      byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0000, 4'b0000); byte_in(8'h75);

      // Down + right, release right then down
      cur_tag = "down_make";   byte_in(8'hE0); set_exp(4'b0001, 4'b0001); byte_in(8'h72);
      cur_tag = "right_make";  byte_in(8'hE0); set_exp(4'b1001, 4'b1000); byte_in(8'h74);
      cur_tag = "right_rel";   byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0001, 4'b0001); byte_in(8'h74);
      cur_tag = "down_rel";    byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0000, 4'b0000); byte_in(8'h72);

      // All four held; one-hot is checked every cycle by the monitor
      cur_tag = "all_up";      byte_in(8'hE0); set_exp(4'b0010, 4'b0010); byte_in(8'h75);
      cur_tag = "all_down";    byte_in(8'hE0); set_exp(4'b0011, 4'b0001); byte_in(8'h72);
      cur_tag = "all_left";    byte_in(8'hE0); set_exp(4'b0111, 4'b0100); byte_in(8'h6B);
      cur_tag = "all_right";   byte_in(8'hE0); set_exp(4'b1111, 4'b1000); byte_in(8'h74);
      cur_tag = "all_rel_r";   byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0111, 4'b0010); byte_in(8'h74);
      cur_tag = "all_rel_u";   byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0101, 4'b0001); byte_in(8'h75);
      cur_tag = "all_rel_d";   byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0100, 4'b0100); byte_in(8'h72);
      cur_tag = "all_rel_l";   byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0000, 4'b0000); byte_in(8'h6B);

      // W aliases UP only when WASD is enabled; arrow break releases it
      cur_tag = "wasd_w";      xh_w = 4'b0010; xm_w = 4'b0010; byte_in(8'h1D);
      cur_tag = "wasd_rel";    byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0000, 4'b0000); byte_in(8'h75);
      cur_tag = "e1_ignored";  byte_in(8'hE1);

      // F0 E0 is malformed: error on E0, then 74 is an extended make
      cur_tag = "bad_f0";      byte_in(8'hF0);
      cur_tag = "bad_e0";      send(8'hE0, 1'b1, 1'b0, 1'b1);
      cur_tag = "bad_74";      set_exp(4'b1000, 4'b1000); byte_in(8'h74);
      // E0 F0 E0: error, back to IDLE, so a bare 74 is unmapped
      cur_tag = "bad_ebrk";    byte_in(8'hE0); byte_in(8'hF0); send(8'hE0, 1'b1, 1'b0, 1'b1);
      cur_tag = "bad_ebrk74";  byte_in(8'h74);
      cur_tag = "right_rel2";  byte_in(8'hE0); byte_in(8'hF0); set_exp(4'b0000, 4'b0000); byte_in(8'h74);

      // clear beats a same-cycle byte and aborts the E0 prefix without error
      cur_tag = "clr_e0";      byte_in(8'hE0);
      cur_tag = "clr_75";      send(8'h75, 1'b1, 1'b1, 1'b0);
      cur_tag = "clr_idle";    byte_in(8'h75);
      cur_tag = "clr_held";    byte_in(8'hE0); set_exp(4'b0010, 4'b0010); byte_in(8'h75);
      cur_tag = "clr_only";    set_exp(4'b0000, 4'b0000); send(8'h00, 1'b0, 1'b1, 1'b0);

      // Async reset with RIGHT held: outputs drop without a clock edge
      cur_tag = "pre_reset";   byte_in(8'hE0); set_exp(4'b1000, 4'b1000); byte_in(8'h74);
      @(negedge clock); #1;
      resetn = 1'b0;
      #1;
      async_check("async_rst");
      @(posedge clock); #1;
      resetn = 1'b1;
      set_exp(4'b0000, 4'b0000);

      // Reset mid-sequence discards the pending E0
      cur_tag = "mid_e0";      byte_in(8'hE0);
      @(negedge clock); #1;
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      @(posedge clock); #1;
      cur_tag = "mid_75";      byte_in(8'h75);

      repeat (3) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
